// File: rtl/byte_serial_mul_pkg.sv
// Shared definitions for the byte-serial RV32M multiplier: widths, funct codes and FSM states.
package byte_serial_mul_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned DIGIT_W    = 8;
    localparam int unsigned NUM_DIGITS = XLEN / DIGIT_W;
    localparam int unsigned CNT_W      = $clog2(NUM_DIGITS);
    localparam int unsigned PP_W       = XLEN + DIGIT_W;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_e;

    // Two's-complement absolute value; 0x80000000 stays 0x80000000 read as unsigned.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic negative);
        return negative ? (~v + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/mul_digit_pp.sv
// Combinational |a| x one multiplier digit partial-product generator.
module mul_digit_pp
    import byte_serial_mul_pkg::*;
(
    input  logic [XLEN-1:0]    a,
    input  logic [DIGIT_W-1:0] digit,
    output logic [PP_W-1:0]    pp
);

    always_comb begin
        pp = PP_W'(a) * PP_W'(digit);
    end

endmodule

// File: rtl/byte_serial_mul.sv
// Multi-cycle RV32M MUL/MULH/MULHSU/MULHU unit consuming |b| one byte per cycle.
// Optional early termination on zero upper bytes of |b|: define MUL_EARLY_OUT_EN.
module byte_serial_mul
    import byte_serial_mul_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [1:0]      funct_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    state_e             state;
    state_e             state_next;
    mul_op_e            op;
    logic [XLEN-1:0]    a_mag;
    logic [XLEN-1:0]    b_mag;
    logic               neg;
    logic               low_half;
    logic [CNT_W-1:0]   cnt;
    logic [2*XLEN-1:0]  acc;
    logic [2*XLEN-1:0]  acc_fixed;
    logic [2*XLEN-1:0]  pp_shifted;
    logic [DIGIT_W-1:0] digit;
    logic [PP_W-1:0]    pp;
    logic               sign_a;
    logic               sign_b;
    logic               last_digit;

    assign op = mul_op_e'(funct_i);

    always_comb begin
        sign_a = ((op == MUL_OP_MULH) || (op == MUL_OP_MULHSU)) && op_a_i[XLEN-1];
        sign_b = (op == MUL_OP_MULH) && op_b_i[XLEN-1];
    end

    assign digit      = DIGIT_W'(b_mag >> (DIGIT_W * cnt));
    assign pp_shifted = (2*XLEN)'(pp) << (DIGIT_W * cnt);
    assign acc_fixed  = neg ? (~acc + (2*XLEN)'(1)) : acc;

    mul_digit_pp u_pp (
        .a     (a_mag),
        .digit (digit),
        .pp    (pp)
    );

`ifdef MUL_EARLY_OUT_EN
    // Stop once every byte of |b| above the current one is zero.
    assign last_digit = (cnt == CNT_W'(NUM_DIGITS - 1)) ||
                        ((b_mag >> (DIGIT_W * (32'(cnt) + 32'd1))) == '0);
`else
    assign last_digit = (cnt == CNT_W'(NUM_DIGITS - 1));
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready_o    = 1'b0;
        valid_o    = 1'b0;
        busy_o     = 1'b1;
        case (state)
            ST_IDLE: begin
                ready_o = 1'b1;
                busy_o  = 1'b0;
                if (valid_i) state_next = ST_CALC;
            end
            ST_CALC: begin
                if (last_digit) state_next = ST_FIX;
            end
            ST_FIX: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                valid_o = 1'b1;
                if (ready_i) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_mag    <= '0;
            b_mag    <= '0;
            neg      <= 1'b0;
            low_half <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            result_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (valid_i) begin
                        a_mag    <= magnitude(op_a_i, sign_a);
                        b_mag    <= magnitude(op_b_i, sign_b);
                        neg      <= sign_a ^ sign_b;
                        low_half <= (op == MUL_OP_MUL);
                        cnt      <= '0;
                        acc      <= '0;
                    end
                end
                ST_CALC: begin
                    acc <= acc + pp_shifted;
                    cnt <= cnt + CNT_W'(1);
                end
                ST_FIX: begin
                    acc      <= acc_fixed;
                    result_o <= low_half ? acc_fixed[XLEN-1:0] : acc_fixed[2*XLEN-1:XLEN];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_mul.sv
// Self-checking bench for byte_serial_mul: arithmetic/latency model plus directed literal vectors.
// Honours MUL_EARLY_OUT_EN for the expected latencies.
module tb_byte_serial_mul;

    logic        clk_i   = 1'b0;
    logic        rst_i   = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] op_a_i  = '0;
    logic [31:0] op_b_i  = '0;
    logic [1:0]  funct_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] result_o;
    logic        busy_o;

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;

`ifdef MUL_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    byte_serial_mul dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .funct_i  (funct_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference product from the architectural definition of each funct.
    function automatic logic [31:0] model_mul(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] ea, eb, p;
        logic sa, sb;
        sa = (f == 2'b01) || (f == 2'b10);
        sb = (f == 2'b01);
        ea = {{34{sa & a[31]}}, a};
        eb = {{34{sb & b[31]}}, b};
        p  = ea * eb;
        return (f == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Cycles from handshake to valid_o.
    function automatic int model_latency(input logic [1:0] f, input logic [31:0] b);
        logic [31:0] bm;
        int n;
        if (!EO) return 6;
        bm = ((f == 2'b01) && b[31]) ? (0 - b) : b;
        n = 1;
        for (int i = 1; i < 4; i++) begin
            if (((bm >> (8 * i)) & 32'hFF) != 0) n = i + 1;
        end
        return 2 + n;
    endfunction

    bit          m_busy  = 1'b0;
    bit          m_valid = 1'b0;
    int          m_count = 0;
    logic [31:0] m_res   = '0;
    logic [31:0] m_pend  = '0;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_count = 0;
            m_res   = '0;
        end else if (m_valid) begin
            if (ready_i) m_valid = 1'b0;
        end else if (m_busy) begin
            m_count--;
            if (m_count == 0) begin
                m_busy  = 1'b0;
                m_valid = 1'b1;
                m_res   = m_pend;
            end
        end else if (valid_i) begin
            m_busy  = 1'b1;
            m_count = model_latency(funct_i, op_b_i) - 1;
            m_pend  = model_mul(funct_i, op_a_i, op_b_i);
        end
    end

    always @(negedge clk_i) begin
        if (cyc >= 1) begin
            chk("ready_o", 32'(ready_o), 32'(!m_busy && !m_valid));
            chk("busy_o", 32'(busy_o), 32'(m_busy || m_valid));
            chk("valid_o", 32'(valid_o), 32'(m_valid));
            chk("result_o", result_o, m_res);
        end
    end

    task automatic run_op(input string name, input logic [1:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int t0;
        @(negedge clk_i);
        funct_i = f;
        op_a_i  = a;
        op_b_i  = b;
        valid_i = 1'b1;
        t0 = cyc;
        @(negedge clk_i);
        valid_i = 1'b0;
        op_a_i  = $urandom;
        op_b_i  = $urandom;
        funct_i = 2'($urandom);
        while (!valid_o && (cyc - t0) < 20) @(negedge clk_i);
        chk({name, " latency"}, 32'(cyc - t0), 32'(exp_lat));
        chk({name, " result"}, result_o, exp_res);
        if (ready_i) begin
            @(negedge clk_i);
            chk({name, " ready_o after result"}, 32'(ready_o), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("reset ready_o", 32'(ready_o), 32'd1);
        chk("reset valid_o", 32'(valid_o), 32'd0);
        chk("reset busy_o", 32'(busy_o), 32'd0);
        chk("reset result_o", result_o, 32'd0);

        run_op("MUL 7*6",          2'b00, 32'd7,        32'd6,        32'h0000002A, EO ? 3 : 6);
        run_op("MULH -1*-1",       2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, EO ? 3 : 6);
        run_op("MULHU max*max",    2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 6);
        run_op("MULHSU min*2^31",  2'b10, 32'h80000000, 32'h80000000, 32'hC0000000, 6);
        run_op("MUL min*2^31",     2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 6);
        run_op("MULH -7*6",        2'b01, 32'hFFFFFFF9, 32'd6,        32'hFFFFFFFF, EO ? 3 : 6);
        run_op("MUL -7*6",         2'b00, 32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, EO ? 3 : 6);
        run_op("MULHSU -1*65536",  2'b10, 32'hFFFFFFFF, 32'h00010000, 32'hFFFFFFFF, EO ? 5 : 6);
        run_op("MUL 0*0",          2'b00, 32'd0,        32'd0,        32'h00000000, EO ? 3 : 6);
        run_op("MUL max*2",        2'b00, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, EO ? 3 : 6);

        // Backpressure: result must hold and a second request must be ignored.
        ready_i = 1'b0;
        run_op("MULHU bp", 2'b11, 32'h12345678, 32'h9ABCDEF0, 32'h0B00EA4E, 6);
        valid_i = 1'b1;
        funct_i = 2'b00;
        op_a_i  = 32'd9;
        op_b_i  = 32'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("bp valid_o held", 32'(valid_o), 32'd1);
            chk("bp result held", result_o, 32'h0B00EA4E);
            chk("bp ready_o low", 32'(ready_o), 32'd0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk_i);
        chk("bp valid_o dropped", 32'(valid_o), 32'd0);
        chk("bp ready_o back", 32'(ready_o), 32'd1);
        chk("bp result kept", result_o, 32'h0B00EA4E);

        // Reset in the middle of CALC discards the operation.
        @(negedge clk_i);
        funct_i = 2'b11;
        op_a_i  = 32'hDEADBEEF;
        op_b_i  = 32'hCAFEF00D;
        valid_i = 1'b1;
        t0 = cyc;
        @(negedge clk_i);
        valid_i = 1'b0;
        @(negedge clk_i);
        #1;
        chk("mid-op busy before reset", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("async reset ready_o", 32'(ready_o), 32'd1);
        chk("async reset valid_o", 32'(valid_o), 32'd0);
        chk("async reset busy_o", 32'(busy_o), 32'd0);
        chk("async reset result_o", result_o, 32'd0);
        chk("reset asserted at T+2", 32'(cyc - t0), 32'd2);
        @(negedge clk_i);
        rst_i = 1'b0;
        run_op("MUL 3*5 after reset", 2'b00, 32'd3, 32'd5, 32'h0000000F, EO ? 3 : 6);

        repeat (3) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
